// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: fetches a message from word-addressed memory and streams it
// as SHA-256 padded 16-word blocks over a valid/ready word interface.
module sha256_msg_padder #(
   parameter int NUM_OF_WORDS = 20
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] message_addr,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   input  logic [31:0] mem_read_data,
   output logic [31:0] blk_word,
   output logic        blk_valid,
   input  logic        blk_ready,
   output logic        blk_last_word,
   output logic        msg_last_block,
   output logic        done
);
   localparam int NB = (NUM_OF_WORDS + 18) / 16;
   localparam logic [9:0]  L_LAST      = 10'(16 * NB - 1);
   localparam logic [9:0]  L_FINAL_BLK = 10'(16 * (NB - 1));
   localparam logic [9:0]  L_W         = 10'(NUM_OF_WORDS);
   localparam logic [31:0] L_BITS      = 32'(NUM_OF_WORDS * 32);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_EMIT} state_t;

   state_t      r_state;
   logic [9:0]  r_n;
   logic [15:0] r_base;
   logic [15:0] r_mem_addr;
   logic [31:0] r_word;
   logic        r_valid;
   logic        r_last_word;
   logic        r_last_block;
   logic [9:0]  w_n1;
   logic [31:0] w_pad;

   assign w_n1  = r_n + 10'd1;
   // Word after the message: the 0x80 marker, the low length word at the very end, zeros between.
   assign w_pad = (w_n1 == L_W) ? 32'h8000_0000 : (w_n1 == L_LAST) ? L_BITS : 32'h0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_n          <= '0;
         r_base       <= '0;
         r_mem_addr   <= '0;
         r_word       <= '0;
         r_valid      <= 1'b0;
         r_last_word  <= 1'b0;
         r_last_block <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_base  <= message_addr;
               r_n     <= '0;
               r_state <= S_RD;
            end
            S_RD: begin
               r_mem_addr <= r_base + 16'(r_n);
               r_state    <= S_CAP;
            end
            S_CAP: begin
               r_word       <= mem_read_data;
               r_valid      <= 1'b1;
               r_last_word  <= r_n[3:0] == 4'hF;
               r_last_block <= r_n >= L_FINAL_BLK;
               r_state      <= S_EMIT;
            end
            S_EMIT: if (blk_ready) begin
               r_n <= w_n1;
               if (r_n == L_LAST) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_n1 < L_W) begin
                  r_valid <= 1'b0;
                  r_state <= S_RD;
               end else begin
                  r_word       <= w_pad;
                  r_last_word  <= w_n1[3:0] == 4'hF;
                  r_last_block <= w_n1 >= L_FINAL_BLK;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_clk        = clk;
   assign mem_we         = 1'b0;
   assign mem_addr       = r_mem_addr;
   assign blk_word       = r_word;
   assign blk_valid      = r_valid;
   assign blk_last_word  = r_last_word;
   assign msg_last_block = r_last_block;
   assign done           = r_state == S_IDLE;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: three message lengths (one and two blocks) checked against a
// word-level padding model through a scoreboard queue and an independent monitor.
module tb_sha256_msg_padder;
   logic clk = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] w;
      logic        lw;
      logic        lb;
   } exp_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int W = g == 0 ? 20 : g == 1 ? 13 : 14;
      localparam int T = 16 * ((W + 18) / 16);

      logic        reset_n = 1'b0;
      logic        start = 1'b0;
      logic        blk_ready = 1'b0;
      logic [15:0] message_addr = '0;
      logic        mem_clk, mem_we, blk_valid, blk_last_word, msg_last_block, done;
      logic [15:0] mem_addr;
      logic [31:0] mem_read_data, blk_word;
      logic [31:0] mem [65536];
      exp_t        q[$];
      int          hs = 0;
      int          rmode = 0;
      int          stalls = 0;
      bit          fin = 1'b0;

      assign mem_read_data = mem[mem_addr];

      sha256_msg_padder #(.NUM_OF_WORDS(W)) dut (
         .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr),
         .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
         .blk_word(blk_word), .blk_valid(blk_valid), .blk_ready(blk_ready),
         .blk_last_word(blk_last_word), .msg_last_block(msg_last_block), .done(done)
      );

      // Reference: the padded message as a flat list of words, from the padding rules.
      task automatic push_msg(input logic [15:0] a);
         exp_t e;
         for (int n = 0; n < T; n++) begin
            e.w  = n < W ? mem[16'(a + n)] : n == W ? 32'h8000_0000 : n == T - 1 ? 32'(W * 32) : 32'h0;
            e.lw = n % 16 == 15;
            e.lb = n >= T - 16;
            q.push_back(e);
         end
      endtask

      task automatic run(input logic [15:0] a, input int mode, input bit poke, input bit rst7);
         rmode = mode;
         stalls = 0;
         hs = 0;
         push_msg(a);
         @(posedge clk); #1;
         start = 1'b1;
         message_addr = a;
         @(posedge clk); #1;
         start = 1'b0;
         message_addr = 16'($urandom);
         chk($sformatf("w%0d done_fall", W), done, 0);
         @(posedge clk); #1;
         chk($sformatf("w%0d lat_gap", W), blk_valid, 0);
         chk($sformatf("w%0d first_addr", W), mem_addr, a);
         @(posedge clk); #1;
         chk($sformatf("w%0d lat_valid", W), blk_valid, 1);
         if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1;
            message_addr = 16'h1234;
            @(posedge clk); #1;
            start = 1'b0;
         end
         if (rst7) begin
            for (int c = 0; c < 40 * T && !(hs == 7 && blk_valid); c++) @(posedge clk) #1;
            chk($sformatf("w%0d reach_word7", W), hs, 7);
            reset_n = 1'b0;
            #1;
            chk($sformatf("w%0d rst_valid", W), blk_valid, 0);
            chk($sformatf("w%0d rst_done", W), done, 1);
            chk($sformatf("w%0d rst_word", W), blk_word, 0);
            q.delete();
            @(posedge clk); #1;
            reset_n = 1'b1;
         end else begin
            for (int c = 0; c < 40 * T && !done; c++) @(posedge clk);
            #1;
            chk($sformatf("w%0d done_end", W), done, 1);
            chk($sformatf("w%0d word_count", W), hs, T);
            chk($sformatf("w%0d q_empty", W), q.size(), 0);
            if (mode == 2) chk($sformatf("w%0d stall_len", W), stalls, 5);
         end
      endtask

      initial forever begin
         @(posedge clk); #1;
         if (rmode == 2 && blk_valid && hs == 3 && stalls < 5) begin
            blk_ready = 1'b0;
            stalls++;
         end else blk_ready = rmode == 1 ? $urandom_range(0, 3) != 0 : 1'b1;
      end

      // Monitor: pops on every handshake, checks holds, memory gaps and padding rate.
      initial begin
         exp_t        e;
         bit          held = 1'b0;
         logic [31:0] hw = '0;
         int          gap = 0;
         int          last = -1;
         forever begin
            @(negedge clk);
            if (!reset_n) begin
               held = 1'b0;
               gap = 0;
               last = -1;
               continue;
            end
            if (held) begin
               chk($sformatf("w%0d hold_valid", W), blk_valid, 1);
               chk($sformatf("w%0d hold_word", W), blk_word, hw);
            end
            if (last >= 0) begin
               if (last == T - 1) begin
                  chk($sformatf("w%0d done_rise", W), done, 1);
                  chk($sformatf("w%0d end_valid", W), blk_valid, 0);
                  last = -1;
               end else if (last + 1 >= W) begin
                  chk($sformatf("w%0d pad_rate", W), blk_valid, 1);
                  last = -1;
               end else begin
                  gap++;
                  chk($sformatf("w%0d mem_gap%0d", W, gap), blk_valid, gap == 3);
                  if (gap == 3) begin
                     gap = 0;
                     last = -1;
                  end
               end
            end
            held = blk_valid && !blk_ready;
            hw = blk_word;
            if (blk_valid && blk_ready) begin
               chk($sformatf("w%0d word%0d_expected", W, hs), q.size() != 0, 1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk($sformatf("w%0d word%0d", W, hs), blk_word, e.w);
                  chk($sformatf("w%0d last_word%0d", W, hs), blk_last_word, e.lw);
                  chk($sformatf("w%0d last_block%0d", W, hs), msg_last_block, e.lb);
               end
               last = hs;
               hs++;
            end
         end
      end

      initial begin
         logic [15:0] a;
         for (int i = 0; i < 65536; i++) mem[i] = i < 20 ? 32'(i + 1) : $urandom;
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("w%0d reset_done", W), done, 1);
         chk($sformatf("w%0d reset_valid", W), blk_valid, 0);
         chk($sformatf("w%0d reset_word", W), blk_word, 0);
         chk($sformatf("w%0d reset_addr", W), mem_addr, 0);
         chk($sformatf("w%0d reset_flags", W), {blk_last_word, msg_last_block}, 0);
         chk($sformatf("w%0d mem_we", W), mem_we, 0);
         chk($sformatf("w%0d mem_clk", W), mem_clk, clk);
         reset_n = 1'b1;
         run(16'h0000, 0, 1'b0, 1'b0);
         run(16'($urandom), 1, 1'b0, 1'b0);
         run(16'hFFFE, 1, 1'b1, 1'b0);
         run(16'($urandom), 2, 1'b0, 1'b0);
         a = 16'($urandom);
         run(a, 0, 1'b0, 1'b1);
         run(a, 0, 1'b0, 1'b0);
         repeat (2) run(16'($urandom), 1, 1'b0, 1'b0);
         fin = 1'b1;
      end
   end

   initial begin
      for (int c = 0; c < 60000 && !(u[0].fin && u[1].fin && u[2].fin); c++) @(posedge clk);
      chk("all_finished", {u[0].fin, u[1].fin, u[2].fin}, 3'b111);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
